// File: rtl/reg_bank_pkg.sv
// Shared definitions for the arbitrated register bank: default sizes,
// requester-id width helper and the write request record.
package reg_bank_pkg;

  localparam int DEF_REQ_NUM    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ZERO_REG   = 1;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/arb_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from a priority
// pointer that moves to one past the last winner.
module arb_rr
  import reg_bank_pkg::*;
#(
  parameter int N  = DEF_REQ_NUM,
  parameter int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic          grant_vld,
  output logic [IW-1:0] grant_id
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
    end
  end

endmodule

// File: rtl/en_reg.sv
// Enabled register with asynchronous active-low reset to a fixed value.
module en_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_arb.sv
// Register bank with one round-robin arbitrated write port and a
// combinational read port; address 0 can be hard-wired to zero.
module reg_bank_arb
  import reg_bank_pkg::*;
#(
  parameter int                    REQ_NUM    = DEF_REQ_NUM,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = '0,
  parameter int                    ZERO_REG   = DEF_ZERO_REG,
  localparam int                   IW         = id_width(REQ_NUM),
  localparam int                   REG_NUM    = 2 ** ADDR_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [REQ_NUM-1:0]               i_req_valid,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]    i_req_data,
  output logic [REQ_NUM-1:0]               o_req_ready,
  output logic                             o_grant_vld,
  output logic [IW-1:0]                    o_grant_id,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data
);

  // Handshake: a requester raises valid independently of ready and holds
  // addr/data/valid until it sees ready; the write commits at the clock edge
  // where valid & ready are both high. Ready is combinational from valid.

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [REG_NUM-1:0]    wr_en;
  logic [DATA_WIDTH-1:0] bank_q [REG_NUM];

  arb_rr #(
    .N  (REQ_NUM),
    .IW (IW)
  ) u_arb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .valid     (i_req_valid),
    .grant     (o_req_ready),
    .grant_vld (o_grant_vld),
    .grant_id  (o_grant_id)
  );

  assign wr_addr = i_req_addr[int'(o_grant_id) * ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_data = i_req_data[int'(o_grant_id) * DATA_WIDTH +: DATA_WIDTH];

  // A zero register still completes the handshake; only the enable is dropped.
  always_comb begin
    wr_en = '0;
    if (o_grant_vld) begin
      wr_en[wr_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      wr_en[0] = 1'b0;
    end
  end

  for (genvar r = 0; r < REG_NUM; r++) begin : g_bank
    en_reg #(
      .W       (DATA_WIDTH),
      .RST_VAL (RSTN_VALUE)
    ) u_reg (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (wr_en[r]),
      .d     (wr_data),
      .q     (bank_q[r])
    );
  end

  assign o_rd_data = ((ZERO_REG != 0) && (i_rd_addr == '0)) ? '0 : bank_q[i_rd_addr];

endmodule

// File: tb/tb_reg_bank_arb.sv
// Bench for reg_bank_arb: two instances (zero register on / off) driven by
// shared stimulus and checked every cycle against a behavioural bank model.
module tb_reg_bank_arb;

  localparam int RN   = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [RN-1:0]    req_valid;
  logic [RN*AW-1:0] req_addr;
  logic [RN*DW-1:0] req_data;
  logic [AW-1:0]    rd_addr;

  logic [RN-1:0] ready_a, ready_b;
  logic          vld_a, vld_b;
  logic [1:0]    id_a, id_b;
  logic [DW-1:0] rd_a, rd_b;

  reg_bank_arb dut_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (ready_a),
    .o_grant_vld (vld_a),
    .o_grant_id  (id_a),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_a)
  );

  reg_bank_arb #(
    .ZERO_REG   (0),
    .RSTN_VALUE (32'hDEAD_BEEF)
  ) dut_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (ready_b),
    .o_grant_vld (vld_b),
    .o_grant_id  (id_b),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [DW-1:0] m_a [NREG];
  logic [DW-1:0] m_b [NREG];
  int            m_ptr;
  int            last_grant;
  bit            model_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // First valid requester when scanning ptr, ptr+1, ... (mod 4); -1 if none.
  function automatic int pick(input logic [RN-1:0] v, input int p);
    logic [1:0] k;
    for (int i = 0; i < RN; i++) begin
      k = 2'(p + i);
      if (v[k]) return int'(k);
    end
    return -1;
  endfunction

  task automatic reset_model();
    for (int r = 0; r < NREG; r++) begin
      m_a[r] = '0;
      m_b[r] = 32'hDEAD_BEEF;
    end
    m_ptr      = 0;
    last_grant = -1;
  endtask

  always @(negedge rst_n) reset_model();

  // model: commit the winning write at each active edge
  always @(posedge clk) begin
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (model_on && rst_n) begin
      g = pick(req_valid, m_ptr);
      last_grant = g;
      if (g >= 0) begin
        a = req_addr[g*AW +: AW];
        d = req_data[g*DW +: DW];
        if (a != '0) m_a[a] = d;
        m_b[a] = d;
        m_ptr = (g + 1) % RN;
      end
    end else begin
      last_grant = -1;
    end
  end

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    int            g;
    logic [RN-1:0] er;
    logic [DW-1:0] ea;
    if (model_on) begin
      g  = pick(req_valid, m_ptr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ea = (rd_addr == '0) ? '0 : m_a[rd_addr];
      chk("ready_a", 64'(ready_a), 64'(er));
      chk("ready_b", 64'(ready_b), 64'(er));
      chk("vld_a",   64'(vld_a),   64'(g >= 0));
      chk("id_a",    64'(id_a),    (g >= 0) ? 64'(g) : 64'd0);
      chk("id_b",    64'(id_b),    (g >= 0) ? 64'(g) : 64'd0);
      chk("rd_a",    64'(rd_a),    64'(ea));
      chk("rd_b",    64'(rd_b),    64'(m_b[rd_addr]));
    end
  end

  // driver tasks
  task automatic drive(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]        = v;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic random_phase(input int cycles);
    logic [RN-1:0] pend;
    logic [AW-1:0] pa [RN];
    logic [DW-1:0] pd [RN];
    pend = '0;
    for (int k = 0; k < RN; k++) begin
      pa[k] = '0;
      pd[k] = '0;
    end
    for (int c = 0; c < cycles; c++) begin
      next_cycle();
      for (int k = 0; k < RN; k++) begin
        if (pend[k] && last_grant == k) pend[k] = 1'b0;
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1'b1;
          pa[k]   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 11));
          pd[k]   = $urandom;
        end
        drive(k, pend[k], pa[k], pd[k]);
      end
      rd_addr = AW'($urandom_range(0, 11));
    end
    next_cycle();
    for (int k = 0; k < RN; k++) drive(k, 1'b0, '0, '0);
  endtask

  initial begin
    reset_model();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr   = '0;
    #2 rst_n = 1'b0;
    model_on = 1'b1;

    // reset contents
    #1 chk("rst_vld", 64'(vld_a), 64'd0);
    for (int r = 0; r < NREG; r++) begin
      rd_addr = AW'(r);
      #1;
      chk("rst_rd_a", 64'(rd_a), 64'd0);
      chk("rst_rd_b", 64'(rd_b), 64'hDEAD_BEEF);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single write, requester 2, address 5
    rd_addr = 5'd5;
    drive(2, 1'b1, 5'd5, 32'h1234_5678);
    #1;
    chk("w5_ready", 64'(ready_a), 64'b0100);
    chk("w5_old_a", 64'(rd_a), 64'd0);
    chk("w5_old_b", 64'(rd_b), 64'hDEAD_BEEF);
    next_cycle();
    drive(2, 1'b0, '0, '0);
    #1;
    chk("w5_new_a", 64'(rd_a), 64'h1234_5678);
    chk("w5_new_b", 64'(rd_b), 64'h1234_5678);

    // zero register write by requester 3 (pointer is 3 here)
    rd_addr = '0;
    drive(3, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1 chk("z_ready", 64'(ready_a), 64'b1000);
    next_cycle();
    drive(3, 1'b0, '0, '0);
    #1;
    chk("z_rd_a", 64'(rd_a), 64'd0);
    chk("z_rd_b", 64'(rd_b), 64'hFFFF_FFFF);

    // requesters 1 and 3 from pointer 0
    drive(1, 1'b1, 5'd6, 32'h1111_1111);
    drive(3, 1'b1, 5'd7, 32'h3333_3333);
    #1 chk("p13_first", 64'(id_a), 64'd1);
    next_cycle();
    drive(1, 1'b0, '0, '0);
    #1 chk("p13_second", 64'(id_a), 64'd3);
    next_cycle();
    drive(3, 1'b0, '0, '0);
    #1 chk("p13_idle", 64'(vld_a), 64'd0);

    // all four valid for eight cycles, pointer back at 0
    for (int k = 0; k < RN; k++) drive(k, 1'b1, AW'(8 + k), 32'hA000_0000 + k);
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_id", 64'(id_a), 64'(c % RN));
      next_cycle();
      drive(c % RN, 1'b1, AW'(8 + c % RN), 32'hB000_0000 + c % RN);
    end
    for (int k = 0; k < RN; k++) drive(k, 1'b0, '0, '0);
    for (int k = 0; k < RN; k++) begin
      rd_addr = AW'(8 + k);
      #1 chk("rr_reg", 64'(rd_a), 64'(32'hB000_0000 + k));
    end

    random_phase(800);

    // reset mid-burst with pointer at 2
    drive(1, 1'b1, 5'd2, 32'hC1C1_C1C1);
    #1 chk("mr_g1", 64'(id_a), 64'd1);
    next_cycle();
    drive(1, 1'b0, '0, '0);
    for (int k = 0; k < RN; k++) drive(k, 1'b1, 5'd3, 32'h5555_0000 + k);
    rd_addr = 5'd2;
    #1 chk("mr_ptr2", 64'(id_a), 64'd2);
    chk("mr_pre_b", 64'(rd_b), 64'hC1C1_C1C1);
    rst_n = 1'b0;
    #1;
    chk("mr_ready", 64'(ready_a), 64'b0001);
    chk("mr_rd_a", 64'(rd_a), 64'd0);
    chk("mr_rd_b", 64'(rd_b), 64'hDEAD_BEEF);
    next_cycle();
    rd_addr = 5'd3;
    #1 chk("mr_nocommit", 64'(rd_b), 64'hDEAD_BEEF);
    for (int k = 0; k < RN; k++) drive(k, 1'b0, '0, '0);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
